// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: FSM encoding, column drive patterns
// and the row/column to key-value map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // One-cold column drive, indexed by column number; rotation is index+1.
  localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [1:0]      COL_FIRST = 2'd0;

  // Key values indexed by {row, col}: r0 {1,2,3,A} r1 {4,5,6,B} r2 {7,8,9,C} r3 {0,F,E,D}.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[{r, c}];
  endfunction

  // Lowest-numbered active-low row; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold column drive, debounces press and
// release, and hands single key events to the consumer over a valid/ack handshake.
// Board hookup: JA[3:0] carries col, JA[7:4] carries row.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LIMIT   = 4'(DEBOUNCE_CNT);

  logic [3:0]  row_meta, row_sync;
  logic [15:0] dwell;
  logic        sample;

  state_t      state, state_next;
  logic [1:0]  col_idx, col_idx_next;
  logic [1:0]  row_idx, row_idx_next;
  logic [3:0]  db_cnt, db_cnt_next;
  logic        accept;

  logic        any_low, match, db_done;

  // NOTE: rows idle high, so the synchronizer resets to 1 to avoid a phantom press.
  always_ff @(posedge clk) begin
    if (Rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign sample = (dwell == DWELL_LAST);

  always_ff @(posedge clk) begin
    if (Rst)         dwell <= '0;
    else if (sample) dwell <= '0;
    else             dwell <= dwell + 16'd1;
  end

  assign any_low = ~&row_sync;
  assign match   = any_low && (lowest_low(row_sync) == row_idx);
  assign db_done = (db_cnt + 4'd1) >= DB_LIMIT;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state   <= SCAN;
      col_idx <= COL_FIRST;
      row_idx <= 2'd0;
      db_cnt  <= '0;
    end else begin
      state   <= state_next;
      col_idx <= col_idx_next;
      row_idx <= row_idx_next;
      db_cnt  <= db_cnt_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_next   = state;
    col_idx_next = col_idx;
    row_idx_next = row_idx;
    db_cnt_next  = db_cnt;
    accept       = 1'b0;
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_next = col_idx + 2'd1;
          end else begin
            row_idx_next = lowest_low(row_sync);
            db_cnt_next  = 4'd1;
            state_next   = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!match) begin
            col_idx_next = col_idx + 2'd1;
            db_cnt_next  = '0;
            state_next   = SCAN;
          end else if (db_done) begin
            accept      = 1'b1;
            db_cnt_next = '0;
            state_next  = HELD;
          end else begin
            db_cnt_next = db_cnt + 4'd1;
          end
        end
        HELD: begin
          if (!any_low) begin
            db_cnt_next = 4'd1;
            state_next  = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (any_low) begin
            db_cnt_next = '0;
            state_next  = HELD;
          end else if (db_done) begin
            col_idx_next = COL_FIRST;
            db_cnt_next  = '0;
            state_next   = SCAN;
          end else begin
            db_cnt_next = db_cnt + 4'd1;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  always_comb begin
    col  = COL_DRIVE[col_idx];
    busy = (state != SCAN);
  end

  // A press accepted while an event is still pending is dropped, even if that
  // event is being acked on the same edge.
  always_ff @(posedge clk) begin
    if (Rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= accept && key_valid;
      if (accept && !key_valid) begin
        key_code  <= key_lookup(row_idx, col_idx);
        key_valid <= 1'b1;
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each column is driven (dwell); legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive identical samples needed to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  system clock, the divided display/game clock; single clock domain.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 row  input  4  keypad row lines, active-low, pulled up externally; asynchronous to clk.
REQ-006 col  output  4  keypad column drive, one-cold: the driven column is 0, the others are 1.
REQ-007 key_code  output  4  decoded key value, stable while key_valid=1.
REQ-008 key_valid  output  1  key event pending for the game controller.
REQ-009 key_ack  input  1  consumer accepts the pending event.
REQ-010 overrun  output  1  one-cycle pulse: a press was debounced while key_valid=1 and was dropped.
REQ-011 busy  output  1  high while the FSM is in any state other than SCAN.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; the sample point is the cycle with count=SCAN_DIV-1.
REQ-014 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN: at each sample point, if all rows read 1, col SHALL rotate 1110->1101->1011->0111->1110; otherwise lock the column, latch the row index, load debounce count 1, and go to PRESS_DB.
REQ-016 If several rows are low at one sample, the lowest row index SHALL win.
REQ-017 PRESS_DB: col stays fixed; at each sample point, a matching row increments the count and a mismatch or all-high returns to SCAN with the column advanced; reaching DEBOUNCE_CNT goes to HELD and accepts the press.
REQ-018 Key map by row r and col c SHALL be: r0 {1,2,3,A}, r1 {4,5,6,B}, r2 {7,8,9,C}, r3 {0,F,E,D}.
REQ-019 On an accepted press with key_valid=0: key_code SHALL load the mapped value and key_valid SHALL rise on the next cycle; with key_valid=1: key_code and key_valid are unchanged and overrun pulses.
REQ-020 HELD: col stays fixed; the first sample with all rows high loads count 1 and goes to RELEASE_DB.
REQ-021 RELEASE_DB: all-high samples increment the count; any low row returns to HELD; reaching DEBOUNCE_CNT goes to SCAN with col=1110.
REQ-022 Handshake: key_valid SHALL clear on the edge that samples key_valid&key_ack=1; key_ack while key_valid=0 SHALL be ignored.
REQ-023 Ack on the same cycle a new press is accepted: the ack clears the old event, the new press is dropped, and overrun pulses.
REQ-024 Latency from a stable press to key_valid=1 SHALL be at most (4+DEBOUNCE_CNT)*SCAN_DIV+3 cycles.
REQ-025 A held key SHALL produce exactly one event; there is no auto-repeat.

Reset
REQ-026 While Rst=1, the block SHALL go to state SCAN with col=1110, dwell and debounce counters 0, synchronizer flops 1, key_code=0, key_valid=0, overrun=0, busy=0.
REQ-027 Rst asserted mid-debounce or mid-hold SHALL discard the pending event; after Rst falls, a key still held SHALL be detected as a new press.

Structure
REQ-028 The key-map table, the state encoding and the column rotation constants SHALL live in the shared package keypad_pkg.
REQ-029 The block is a single module with no sub-modules; the synchronizer is inline.
REQ-030 Output ports are compatible with the existing Decoder: JA[3:0] carries col and JA[7:4] carries row.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-031 Hold row1/col2 low -> key_code=6 with key_valid=1 within 31 cycles; assert key_ack -> key_valid=0 on the next cycle; no second event while held.
REQ-032 Row1 bounces low for 1 sample then returns high -> no key_valid, FSM back in SCAN, col keeps rotating.
REQ-033 Press 5, do not ack, release, press 9 -> overrun pulses once and key_code stays 5.
REQ-034 Row0 and row3 low together on col0 -> key_code=1.
REQ-035 Rst during PRESS_DB and during HELD -> all outputs return to reset values; a key still held after reset yields exactly one new event.
REQ-036 Release glitch (1 low sample during RELEASE_DB) -> return to HELD, no new event, and a full release is still required before the next press is accepted.
